// File: rtl/mem_indirect_seq_pkg.sv
// Shared LC-3b types for the MEM-stage indirect-access sequencer.
package mem_indirect_seq_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb  = 4'b0011,
    op_jsr  = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str  = 4'b0111,
    op_rti  = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti  = 4'b1011,
    op_jmp  = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode  opcode;
    logic        load_regfile;
    logic [1:0]  marmux_sel;
    logic [1:0]  mdrmux_sel;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  dest;
  } lc3b_control_word;

  localparam logic [1:0] MARMUX_PTR = 2'b10;
  localparam logic [1:0] MDRMUX_SRC = 2'b00;

  typedef enum logic [1:0] {IDLE, HOP, FINAL} mem_seq_state_t;

  function automatic logic is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/mem_indirect_seq_if.sv
// MEM-stage control word / data-memory handshake bundle for the sequencer.
interface mem_indirect_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  import mem_indirect_seq_pkg::*;

  logic              valid_in;
  lc3b_control_word  ctrl_word_in;
  logic              data_response;
  logic [DATA_W-1:0] data_rdata;
  lc3b_control_word  ctrl_word_out;
  logic [ADDR_W-1:0] addr_ptr;
  logic              stall;
  logic              done;
  logic [3:0]        hop_cnt;
  logic              timeout_err;

  modport master (
    output valid_in, ctrl_word_in, data_response, data_rdata,
    input  ctrl_word_out, addr_ptr, stall, done, hop_cnt, timeout_err
  );

  modport slave (
    input  valid_in, ctrl_word_in, data_response, data_rdata,
    output ctrl_word_out, addr_ptr, stall, done, hop_cnt, timeout_err
  );
endinterface

// File: rtl/mem_indirect_seq_timer.sv
// Per-access response wait counter; saturates at TIMEOUT, TIMEOUT=0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
endmodule

// File: rtl/mem_indirect_seq.sv
// MEM-stage LDI/STI sequencer: chases MAX_HOPS pointers, then performs the final access.
module mem_indirect_seq
  import mem_indirect_seq_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_HOPS = 1,
  parameter int TIMEOUT  = 255
) (
  input logic             clk,
  input logic             reset,
  mem_indirect_seq_if.slave bus
);
  mem_seq_state_t   state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, rdata_ext;
  logic [3:0]        hop_q, hop_d;
  logic              is_store_q, is_store_d;
  logic              err_q, err_d;
  lc3b_control_word  cw;
  logic              stall, done, expired;

  if (DATA_W >= ADDR_W) begin : g_trunc
    assign rdata_ext = bus.data_rdata[ADDR_W-1:0];
  end else begin : g_zext
    assign rdata_ext = {{(ADDR_W-DATA_W){1'b0}}, bus.data_rdata};
  end

  // Clearing while IDLE covers entry to the first access; a response starts the next one.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_q == IDLE) || bus.data_response),
    .enable_i  (state_q != IDLE),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hop_q      <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hop_q      <= hop_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    cw         = bus.ctrl_word_in;
    state_d    = state_q;
    ptr_d      = ptr_q;
    hop_d      = hop_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    stall      = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_in && is_indirect(bus.ctrl_word_in.opcode)) begin
          stall      = 1'b1;
          is_store_d = (bus.ctrl_word_in.opcode == op_sti);
          hop_d      = '0;
          state_d    = HOP;
        end
      end
      HOP: begin
        cw.mem_read  = 1'b1;
        cw.mem_write = 1'b0;
        cw.marmux_sel = (hop_q == 4'd0) ? bus.ctrl_word_in.marmux_sel : MARMUX_PTR;
        stall = 1'b1;
        if (bus.data_response) begin
          ptr_d = rdata_ext;
          hop_d = hop_q + 4'd1;
          if (hop_q == 4'(MAX_HOPS - 1)) state_d = FINAL;
        end
      end
      FINAL: begin
        cw.marmux_sel = MARMUX_PTR;
        if (is_store_q) begin
          cw.mem_read   = 1'b0;
          cw.mem_write  = 1'b1;
          cw.mdrmux_sel = MDRMUX_SRC;
        end else begin
          cw.mem_read  = 1'b1;
          cw.mem_write = 1'b0;
        end
        stall = 1'b1;
        if (bus.data_response) begin
          stall   = 1'b0;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response in the expiry cycle takes precedence over the timeout.
    if ((state_q != IDLE) && expired && !bus.data_response) begin
      err_d        = 1'b1;
      state_d      = IDLE;
      stall        = 1'b0;
      done         = 1'b0;
      cw.mem_read  = 1'b0;
      cw.mem_write = 1'b0;
    end

    if (reset) begin
      cw.mem_read  = 1'b0;
      cw.mem_write = 1'b0;
      stall        = 1'b0;
      done         = 1'b0;
    end
  end

  assign bus.ctrl_word_out = cw;
  assign bus.addr_ptr      = ptr_q;
  assign bus.stall         = stall;
  assign bus.done          = done;
  assign bus.hop_cnt       = hop_q;
  assign bus.timeout_err   = err_q;
endmodule

// File: tb/tb_mem_indirect_seq.sv
// Directed bench: dut_a is classic LDI/STI (1 hop, TIMEOUT=8), dut_b chases 3 pointers.
module tb_mem_indirect_seq;
  import mem_indirect_seq_pkg::*;

  logic clk, rst_a, rst_b;
  int   checks, errors;

  mem_indirect_seq_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  mem_indirect_seq_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  mem_indirect_seq #(.ADDR_W(16), .DATA_W(16), .MAX_HOPS(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );
  mem_indirect_seq #(.ADDR_W(16), .DATA_W(16), .MAX_HOPS(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  function automatic lc3b_control_word mk(lc3b_opcode op, logic [1:0] mar, logic [1:0] mdr,
                                          logic rd, logic wr, logic ld, logic [2:0] dst);
    lc3b_control_word w;
    w.opcode = op; w.marmux_sel = mar; w.mdrmux_sel = mdr;
    w.mem_read = rd; w.mem_write = wr; w.load_regfile = ld; w.dest = dst;
    return w;
  endfunction

  function automatic lc3b_control_word ovr(lc3b_control_word w, logic [1:0] mar, logic [1:0] mdr,
                                           logic rd, logic wr);
    w.marmux_sel = mar; w.mdrmux_sel = mdr; w.mem_read = rd; w.mem_write = wr;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic v, input lc3b_control_word w,
                         input logic resp, input logic [15:0] d);
    @(negedge clk);
    rst_a = r; bus_a.valid_in = v; bus_a.ctrl_word_in = w;
    bus_a.data_response = resp; bus_a.data_rdata = d;
    #1;
  endtask

  task automatic drive_b(input logic r, input logic v, input lc3b_control_word w,
                         input logic resp, input logic [15:0] d);
    @(negedge clk);
    rst_b = r; bus_b.valid_in = v; bus_b.ctrl_word_in = w;
    bus_b.data_response = resp; bus_b.data_rdata = d;
    #1;
  endtask

  lc3b_control_word LDI_W, STI_W, LDR_W;

  initial begin
    clk = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    checks = 0; errors = 0;
    LDI_W = mk(op_ldi, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 3'd3);
    STI_W = mk(op_sti, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 3'd5);
    LDR_W = mk(op_ldr, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 3'd2);
    bus_a.valid_in = 1'b0; bus_a.ctrl_word_in = LDR_W; bus_a.data_response = 1'b0; bus_a.data_rdata = '0;
    bus_b.valid_in = 1'b0; bus_b.ctrl_word_in = LDR_W; bus_b.data_response = 1'b0; bus_b.data_rdata = '0;

    // Reset: memory strobes masked, no stall
    drive_a(1, 1, LDR_W, 0, 16'h0);
    chk("rst_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDR_W, 2'b01, 2'b01, 0, 0)));
    chk("rst_stall", 32'(bus_a.stall), 32'd0);
    drive_b(0, 0, LDR_W, 0, 16'h0);
    drive_a(0, 0, LDR_W, 0, 16'h0);
    chk("rst_hop", 32'(bus_a.hop_cnt), 32'd0);
    chk("rst_ptr", 32'(bus_a.addr_ptr), 32'd0);
    chk("rst_err", 32'(bus_a.timeout_err), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("idle_pass", 32'(bus_a.ctrl_word_out), 32'(LDR_W));

    // Response while IDLE is ignored
    drive_a(0, 0, LDR_W, 1, 16'hFFFF);
    chk("idle_resp_stall", 32'(bus_a.stall), 32'd0);
    drive_a(0, 0, LDR_W, 0, 16'h0);
    chk("idle_resp_ptr", 32'(bus_a.addr_ptr), 32'd0);

    // 1: LDI, first response after 3 cycles, second after 2
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t1_entry_stall", 32'(bus_a.stall), 32'd1);
    chk("t1_entry_cw", 32'(bus_a.ctrl_word_out), 32'(LDI_W));
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t1_hop_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDI_W, 2'b01, 2'b01, 1, 0)));
    chk("t1_hop_cnt", 32'(bus_a.hop_cnt), 32'd0);
    drive_a(0, 1, LDI_W, 0, 16'h0);
    drive_a(0, 1, LDI_W, 1, 16'h3000);
    chk("t1_hop_resp_stall", 32'(bus_a.stall), 32'd1);
    chk("t1_hop_resp_done", 32'(bus_a.done), 32'd0);
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t1_fin_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDI_W, 2'b10, 2'b01, 1, 0)));
    chk("t1_fin_ptr", 32'(bus_a.addr_ptr), 32'h3000);
    chk("t1_fin_hop", 32'(bus_a.hop_cnt), 32'd1);
    chk("t1_fin_stall", 32'(bus_a.stall), 32'd1);
    drive_a(0, 1, LDI_W, 1, 16'h0);
    chk("t1_done", 32'(bus_a.done), 32'd1);
    chk("t1_done_stall", 32'(bus_a.stall), 32'd0);
    drive_a(0, 0, LDR_W, 0, 16'h0);
    chk("t1_after_done", 32'(bus_a.done), 32'd0);
    chk("t1_after_stall", 32'(bus_a.stall), 32'd0);

    // 2: STI
    drive_a(0, 1, STI_W, 0, 16'h0);
    chk("t2_entry_stall", 32'(bus_a.stall), 32'd1);
    drive_a(0, 1, STI_W, 1, 16'h4002);
    chk("t2_hop_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(STI_W, 2'b01, 2'b01, 1, 0)));
    drive_a(0, 1, STI_W, 0, 16'h0);
    chk("t2_fin_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(STI_W, 2'b10, 2'b00, 0, 1)));
    chk("t2_fin_ptr", 32'(bus_a.addr_ptr), 32'h4002);
    chk("t2_fin_done", 32'(bus_a.done), 32'd0);
    drive_a(0, 1, STI_W, 1, 16'h0);
    chk("t2_done", 32'(bus_a.done), 32'd1);
    chk("t2_done_stall", 32'(bus_a.stall), 32'd0);

    // 6: back-to-back LDI, STI, then plain LDR
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t6_ldi_entry", 32'(bus_a.stall), 32'd1);
    drive_a(0, 1, LDI_W, 1, 16'h1234);
    drive_a(0, 1, LDI_W, 1, 16'h0);
    chk("t6_ldi_done", 32'(bus_a.done), 32'd1);
    drive_a(0, 1, STI_W, 0, 16'h0);
    chk("t6_sti_entry_stall", 32'(bus_a.stall), 32'd1);
    chk("t6_sti_entry_cw", 32'(bus_a.ctrl_word_out), 32'(STI_W));
    drive_a(0, 1, STI_W, 1, 16'h5678);
    chk("t6_sti_hop_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(STI_W, 2'b01, 2'b01, 1, 0)));
    drive_a(0, 1, STI_W, 1, 16'h0);
    chk("t6_sti_fin_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(STI_W, 2'b10, 2'b00, 0, 1)));
    chk("t6_sti_fin_ptr", 32'(bus_a.addr_ptr), 32'h5678);
    chk("t6_sti_done", 32'(bus_a.done), 32'd1);
    drive_a(0, 1, LDR_W, 0, 16'h0);
    chk("t6_ldr_stall", 32'(bus_a.stall), 32'd0);
    chk("t6_ldr_cw", 32'(bus_a.ctrl_word_out), 32'(LDR_W));

    // 4b: response in the expiry cycle wins
    drive_a(0, 1, LDI_W, 0, 16'h0);
    for (int i = 0; i < 8; i++) drive_a(0, 1, LDI_W, 0, 16'h0);
    drive_a(0, 1, LDI_W, 1, 16'h0042);
    chk("t4b_resp_stall", 32'(bus_a.stall), 32'd1);
    chk("t4b_resp_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDI_W, 2'b01, 2'b01, 1, 0)));
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t4b_err", 32'(bus_a.timeout_err), 32'd0);
    chk("t4b_fin_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDI_W, 2'b10, 2'b01, 1, 0)));
    chk("t4b_fin_ptr", 32'(bus_a.addr_ptr), 32'h0042);
    drive_a(0, 1, LDI_W, 1, 16'h0);
    chk("t4b_done", 32'(bus_a.done), 32'd1);

    // 4: no response -> timeout
    drive_a(0, 1, LDI_W, 0, 16'h0);
    for (int i = 0; i < 8; i++) drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t4_pre_stall", 32'(bus_a.stall), 32'd1);
    chk("t4_pre_err", 32'(bus_a.timeout_err), 32'd0);
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t4_to_stall", 32'(bus_a.stall), 32'd0);
    chk("t4_to_done", 32'(bus_a.done), 32'd0);
    chk("t4_to_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDI_W, 2'b01, 2'b01, 0, 0)));
    drive_a(0, 0, LDI_W, 0, 16'h0);
    chk("t4_err", 32'(bus_a.timeout_err), 32'd1);
    chk("t4_idle_stall", 32'(bus_a.stall), 32'd0);
    drive_a(0, 0, LDI_W, 0, 16'h0);
    chk("t4_err_sticky", 32'(bus_a.timeout_err), 32'd1);

    // 5: reset during HOP aborts
    drive_a(0, 1, LDI_W, 0, 16'h0);
    drive_a(0, 1, LDI_W, 0, 16'h0);
    chk("t5_hop_stall", 32'(bus_a.stall), 32'd1);
    drive_a(1, 1, LDI_W, 0, 16'h0);
    chk("t5_rst_cw", 32'(bus_a.ctrl_word_out), 32'(ovr(LDI_W, 2'b01, 2'b01, 0, 0)));
    chk("t5_rst_stall", 32'(bus_a.stall), 32'd0);
    drive_a(0, 0, LDI_W, 0, 16'h0);
    chk("t5_post_stall", 32'(bus_a.stall), 32'd0);
    chk("t5_post_rd", 32'(bus_a.ctrl_word_out.mem_read), 32'd0);
    chk("t5_post_err", 32'(bus_a.timeout_err), 32'd0);
    chk("t5_post_done", 32'(bus_a.done), 32'd0);
    drive_a(0, 1, LDR_W, 0, 16'h0);
    chk("t5_ldr_cw", 32'(bus_a.ctrl_word_out), 32'(LDR_W));
    chk("t5_ldr_stall", 32'(bus_a.stall), 32'd0);

    // 3: MAX_HOPS=3 chase
    drive_b(0, 1, LDI_W, 0, 16'h0);
    chk("t3_entry_stall", 32'(bus_b.stall), 32'd1);
    drive_b(0, 1, LDI_W, 1, 16'h1000);
    chk("t3_h0_hop", 32'(bus_b.hop_cnt), 32'd0);
    chk("t3_h0_cw", 32'(bus_b.ctrl_word_out), 32'(ovr(LDI_W, 2'b01, 2'b01, 1, 0)));
    drive_b(0, 1, LDI_W, 1, 16'h2000);
    chk("t3_h1_hop", 32'(bus_b.hop_cnt), 32'd1);
    chk("t3_h1_cw", 32'(bus_b.ctrl_word_out), 32'(ovr(LDI_W, 2'b10, 2'b01, 1, 0)));
    chk("t3_h1_ptr", 32'(bus_b.addr_ptr), 32'h1000);
    drive_b(0, 1, LDI_W, 1, 16'h3000);
    chk("t3_h2_hop", 32'(bus_b.hop_cnt), 32'd2);
    chk("t3_h2_ptr", 32'(bus_b.addr_ptr), 32'h2000);
    chk("t3_h2_stall", 32'(bus_b.stall), 32'd1);
    drive_b(0, 1, LDI_W, 1, 16'h0);
    chk("t3_fin_hop", 32'(bus_b.hop_cnt), 32'd3);
    chk("t3_fin_ptr", 32'(bus_b.addr_ptr), 32'h3000);
    chk("t3_fin_cw", 32'(bus_b.ctrl_word_out), 32'(ovr(LDI_W, 2'b10, 2'b01, 1, 0)));
    chk("t3_done", 32'(bus_b.done), 32'd1);
    chk("t3_done_stall", 32'(bus_b.stall), 32'd0);
    drive_b(0, 0, LDR_W, 0, 16'h0);
    chk("t3_after_done", 32'(bus_b.done), 32'd0);
    chk("t3_after_stall", 32'(bus_b.stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
